// File: rtl/stream_demux.sv
// Registered 1:2^SEL_WIDTH stream demultiplexer with a one-entry register per lane.
// Define DEMUX_PKT_LOCK_EN to hold the destination lane fixed for a whole packet.
module stream_demux #(
    parameter int SEL_WIDTH  = 1,
    parameter int DATA_WIDTH = 8,
    localparam int NL        = 2 ** SEL_WIDTH
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [DATA_WIDTH-1:0]    In,
    input  logic [SEL_WIDTH-1:0]     InSel,
    input  logic                     InValid,
    input  logic                     InLast,
    output logic                     InReady,
    output logic [NL*DATA_WIDTH-1:0] Out,
    output logic [NL-1:0]            OutValid,
    output logic [NL-1:0]            OutLast,
    input  logic [NL-1:0]            OutReady
);

    logic [DATA_WIDTH-1:0] data_q [NL];
    logic [DATA_WIDTH-1:0] data_d [NL];
    logic [NL-1:0]         full_q, full_d;
    logic [NL-1:0]         last_q, last_d;
    logic [SEL_WIDTH-1:0]  tgt;
    logic                  in_acc;

`ifdef DEMUX_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t               state_q;
    logic [SEL_WIDTH-1:0] lock_q;

    assign tgt = (state_q == LOCKED) ? lock_q : InSel;

    // The lane is latched on the first beat of a multi-beat packet and released by its last beat.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else if (in_acc) begin
            if (state_q == IDLE) begin
                if (!InLast) begin
                    state_q <= LOCKED;
                    lock_q  <= InSel;
                end
            end else if (InLast) begin
                state_q <= IDLE;
            end
        end
    end
`else
    assign tgt = InSel;
`endif

    // Ready looks only at the target lane, so a stalled lane never blocks traffic to others.
    assign InReady = !full_q[tgt] || OutReady[tgt];
    assign in_acc  = InValid && InReady;

    always_comb begin
        full_d = full_q;
        last_d = last_q;
        for (int k = 0; k < NL; k++) begin
            data_d[k] = data_q[k];
            if (in_acc && (tgt == SEL_WIDTH'(k))) begin
                data_d[k] = In;
                last_d[k] = InLast;
                full_d[k] = 1'b1;
            end else if (OutReady[k]) begin
                full_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            full_q <= '0;
            last_q <= '0;
            for (int k = 0; k < NL; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            full_q <= full_d;
            last_q <= last_d;
            for (int k = 0; k < NL; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Lane 0 sits in the most-significant slice of Out.
    for (genvar g = 0; g < NL; g++) begin : g_out
        assign Out[(NL-1-g)*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
    end

    assign OutValid = full_q;
    assign OutLast  = last_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed table-driven bench for stream_demux with four 8-bit lanes.
// Lock-dependent expectations follow DEMUX_PKT_LOCK_EN.
module tb_stream_demux;

    logic        Clk;
    logic        Rst_n;
    logic [7:0]  In;
    logic [1:0]  InSel;
    logic        InValid;
    logic        InLast;
    logic        InReady;
    logic [31:0] Out;
    logic [3:0]  OutValid;
    logic [3:0]  OutLast;
    logic [3:0]  OutReady;

    int checks = 0;
    int errors = 0;

    stream_demux #(.SEL_WIDTH(2), .DATA_WIDTH(8)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In(In), .InSel(InSel), .InValid(InValid),
        .InLast(InLast), .InReady(InReady), .Out(Out), .OutValid(OutValid),
        .OutLast(OutLast), .OutReady(OutReady)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic [7:0]  d;
        logic        last;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_vld;
        logic [31:0] exp_out;
        logic [3:0]  exp_last;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lane(input logic [31:0] o, input int l);
        return o[(3-l)*8 +: 8];
    endfunction

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic l, input logic [3:0] r);
        @(negedge Clk);
        InValid  = v;
        InSel    = s;
        In       = d;
        InLast   = l;
        OutReady = r;
    endtask

    logic [1:0] pk_sel  [4];
    logic [7:0] pk_dat  [4];
    int         exp_lane;

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 8'h11, 1'b1, 4'b1111, 1'b1, 4'b0001, 32'h11000000, 4'b0001};
        tbl[1]  = '{1'b1, 2'd3, 8'h22, 1'b1, 4'b1111, 1'b1, 4'b1000, 32'h11000022, 4'b1001};
        tbl[2]  = '{1'b1, 2'd1, 8'h33, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h11330022, 4'b1011};
        tbl[3]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h11330022, 4'b1011};
        tbl[4]  = '{1'b1, 2'd2, 8'hA5, 1'b1, 4'b1011, 1'b1, 4'b0100, 32'h1133A522, 4'b1111};
        tbl[5]  = '{1'b1, 2'd2, 8'h5A, 1'b1, 4'b1011, 1'b0, 4'b0100, 32'h1133A522, 4'b1111};
        tbl[6]  = '{1'b1, 2'd2, 8'h5A, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h11335A22, 4'b1111};
        tbl[7]  = '{1'b1, 2'd1, 8'h77, 1'b1, 4'b1001, 1'b1, 4'b0110, 32'h11775A22, 4'b1111};
        tbl[8]  = '{1'b1, 2'd0, 8'h44, 1'b1, 4'b1001, 1'b1, 4'b0111, 32'h44775A22, 4'b1111};
        tbl[9]  = '{1'b1, 2'd1, 8'h88, 1'b1, 4'b1001, 1'b0, 4'b0110, 32'h44775A22, 4'b1111};
        tbl[10] = '{1'b0, 2'd1, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h44775A22, 4'b1111};

        pk_sel[0] = 2'd2; pk_sel[1] = 2'd0; pk_sel[2] = 2'd1; pk_sel[3] = 2'd3;
        pk_dat[0] = 8'hB1; pk_dat[1] = 8'hB2; pk_dat[2] = 8'hB3; pk_dat[3] = 8'hB4;

        Rst_n = 1'b0; InValid = 1'b0; InSel = '0; In = '0; InLast = 1'b0; OutReady = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_vld", {28'd0, OutValid}, 32'h0);
        chk("reset_last", {28'd0, OutLast}, 32'h0);
        chk("reset_out", Out, 32'h0);
        chk("reset_rdy", {31'd0, InReady}, 32'h1);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].last, tbl[i].ordy);
            #1;
            chk($sformatf("v%0d_rdy", i), {31'd0, InReady}, {31'd0, tbl[i].exp_rdy});
            @(posedge Clk);
            #1;
            chk($sformatf("v%0d_vld", i), {28'd0, OutValid}, {28'd0, tbl[i].exp_vld});
            chk($sformatf("v%0d_out", i), Out, tbl[i].exp_out);
            chk($sformatf("v%0d_last", i), {28'd0, OutLast}, {28'd0, tbl[i].exp_last});
        end

        // Four-beat packet whose later beats carry changing InSel.
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, pk_sel[b], pk_dat[b], (b == 3), 4'b1111);
            #1;
            chk($sformatf("pk%0d_rdy", b), {31'd0, InReady}, 32'h1);
            @(posedge Clk);
            #1;
`ifdef DEMUX_PKT_LOCK_EN
            exp_lane = 2;
`else
            exp_lane = int'(pk_sel[b]);
`endif
            chk($sformatf("pk%0d_vld", b), {28'd0, OutValid}, 32'(1 << exp_lane));
            chk($sformatf("pk%0d_data", b), {24'd0, lane(Out, exp_lane)}, {24'd0, pk_dat[b]});
            chk($sformatf("pk%0d_last", b), {31'd0, OutLast[exp_lane]}, {31'd0, (b == 3)});
        end
        drive(1'b1, 2'd0, 8'hC0, 1'b1, 4'b1111);
        @(posedge Clk);
        #1;
        chk("post_pkt_vld", {28'd0, OutValid}, 32'h1);
        chk("post_pkt_data", {24'd0, lane(Out, 0)}, 32'hC0);

        // Reset in the middle of a packet with buffered beats.
        drive(1'b1, 2'd0, 8'hD1, 1'b0, 4'b0000);
        drive(1'b1, 2'd1, 8'hD2, 1'b0, 4'b0001);
        @(negedge Clk);
        Rst_n = 1'b0; InValid = 1'b0; OutReady = 4'b0000;
        @(posedge Clk);
        #1;
        chk("mid_rst_vld", {28'd0, OutValid}, 32'h0);
        chk("mid_rst_last", {28'd0, OutLast}, 32'h0);
        chk("mid_rst_out", Out, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        InValid = 1'b1; InSel = 2'd1; In = 8'hE1; InLast = 1'b1; OutReady = 4'b0000;
        #1;
        chk("after_rst_rdy", {31'd0, InReady}, 32'h1);
        @(posedge Clk);
        #1;
        chk("after_rst_vld", {28'd0, OutValid}, 32'h2);
        chk("after_rst_data", {24'd0, lane(Out, 1)}, 32'hE1);
        chk("after_rst_last", {28'd0, OutLast}, 32'h2);
        @(negedge Clk);
        InValid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
